md_unit: RTL and testbench

//  Multiply/divide unit for the execute stage; operates alongside the ALU and feeds the memory stage.

---
 rtl/md_unit_if.sv | 25 ++
 rtl/md_unit.sv | 141 ++++++++++++++
 tb/tb_md_unit.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/md_unit_if.sv
// Multiply/divide unit bus: E-stage op/operands, D-stage use flag, HI/LO read port.
// master drives op/operands/controls; slave (md_unit) returns busy/stall/HI/LO/md_out.
interface md_unit_if;
    logic [2:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        IntReq;
    logic        md_use_D;
    logic        rd_sel;
    logic        busy;
    logic        stall_md;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] md_out;

    modport master (
        output md_op, A, B, IntReq, md_use_D, rd_sel,
        input  busy, stall_md, HI, LO, md_out
    );

    modport slave (
        input  md_op, A, B, IntReq, md_use_D, rd_sel,
        output busy, stall_md, HI, LO, md_out
    );
endinterface

// File: rtl/md_unit.sv
// Execute-stage multiply/divide unit holding architectural HI/LO.
// Ports: clk, reset (sync, active-high), bus (md_unit_if.slave: op/operands in, busy/stall/HI/LO/md_out out).
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic     clk,
    input logic     reset,
    md_unit_if.slave bus
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [31:0]   hi_p_q, hi_p_d, lo_p_q, lo_p_d;

    logic is_mul, is_mulu, is_div, is_divu, is_mthi, is_mtlo;
    logic is_start, is_mt, busy, start_acc, mt_acc;

    logic [63:0] prod_s, prod_u;
    logic [31:0] abs_a, abs_b, den_s, den_u;
    logic [31:0] sq_m, sr_m, sq, sr, uq, ur;
    logic [31:0] res_hi, res_lo;
    logic        b_zero;

    always_comb begin
        is_mul  = 1'b0;
        is_mulu = 1'b0;
        is_div  = 1'b0;
        is_divu = 1'b0;
        is_mthi = 1'b0;
        is_mtlo = 1'b0;
        unique case (bus.md_op)
            3'd1:    is_mul  = 1'b1;
            3'd2:    is_mulu = 1'b1;
            3'd3:    is_div  = 1'b1;
            3'd4:    is_divu = 1'b1;
            3'd5:    is_mthi = 1'b1;
            3'd6:    is_mtlo = 1'b1;
            default: ;
        endcase
        is_start = is_mul | is_mulu | is_div | is_divu;
        is_mt    = is_mthi | is_mtlo;
    end

    // Signed divide is done on magnitudes; this also makes
    // 0x80000000 / -1 come out as 0x80000000 rem 0 without overflow.
    always_comb begin
        prod_s = $signed({{32{bus.A[31]}}, bus.A}) * $signed({{32{bus.B[31]}}, bus.B});
        prod_u = {32'd0, bus.A} * {32'd0, bus.B};
        b_zero = (bus.B == 32'd0);
        abs_a  = bus.A[31] ? -bus.A : bus.A;
        abs_b  = bus.B[31] ? -bus.B : bus.B;
        den_s  = b_zero ? 32'd1 : abs_b;
        den_u  = b_zero ? 32'd1 : bus.B;
        sq_m   = abs_a / den_s;
        sr_m   = abs_a % den_s;
        sq     = (bus.A[31] ^ bus.B[31]) ? -sq_m : sq_m;
        sr     = bus.A[31] ? -sr_m : sr_m;
        uq     = bus.A / den_u;
        ur     = bus.A % den_u;
        // Divide by zero re-commits the current HI/LO at the end.
        res_hi = hi_q;
        res_lo = lo_q;
        if (is_mul) begin
            {res_hi, res_lo} = prod_s;
        end else if (is_mulu) begin
            {res_hi, res_lo} = prod_u;
        end else if (is_div && !b_zero) begin
            res_hi = sr;
            res_lo = sq;
        end else if (is_divu && !b_zero) begin
            res_hi = ur;
            res_lo = uq;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            hi_p_q  <= '0;
            lo_p_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            hi_p_q  <= hi_p_d;
            lo_p_q  <= lo_p_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        hi_p_d  = hi_p_q;
        lo_p_d  = lo_p_q;
        unique case (state_q)
            IDLE: begin
                if (start_acc) begin
                    state_d = BUSY;
                    cnt_d   = (is_mul | is_mulu) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                    hi_p_d  = res_hi;
                    lo_p_d  = res_lo;
                end else if (mt_acc) begin
                    if (is_mthi) hi_d = bus.A;
                    if (is_mtlo) lo_d = bus.A;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    hi_d    = hi_p_q;
                    lo_d    = lo_p_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy         = (state_q == BUSY);
        start_acc    = is_start & ~bus.IntReq & ~busy;
        mt_acc       = is_mt & ~bus.IntReq & ~busy;
        bus.busy     = busy;
        bus.stall_md = bus.md_use_D & (busy | start_acc);
        bus.HI       = hi_q;
        bus.LO       = lo_q;
        bus.md_out   = bus.rd_sel ? lo_q : hi_q;
    end
endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: arithmetic reference model plus directed vectors.
// Drives the interface master side; compares all outputs every negedge.
module tb_md_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    bit   check_en = 1'b0;

    md_unit_if intf ();

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (intf.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic and a countdown of busy cycles.
    int          m_left = 0;
    bit          m_keep = 0;
    logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
    longint      sa, sb, sq, sr;
    logic [63:0] pm;

    always @(posedge clk) begin
        if (reset) begin
            m_left = 0;
            m_hi   = 0;
            m_lo   = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && !m_keep) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end else if (!intf.IntReq) begin
            sa     = longint'($signed(intf.A));
            sb     = longint'($signed(intf.B));
            m_keep = 0;
            case (intf.md_op)
                3'd1: begin pm = 64'(sa * sb); {p_hi, p_lo} = pm; m_left = 5; end
                3'd2: begin pm = {32'd0, intf.A} * {32'd0, intf.B}; {p_hi, p_lo} = pm; m_left = 5; end
                3'd3: begin
                    m_left = 10;
                    if (sb == 0) m_keep = 1;
                    else begin
                        sq = sa / sb; sr = sa % sb;
                        p_lo = sq[31:0]; p_hi = sr[31:0];
                    end
                end
                3'd4: begin
                    m_left = 10;
                    if (intf.B == 0) m_keep = 1;
                    else begin p_lo = intf.A / intf.B; p_hi = intf.A % intf.B; end
                end
                3'd5: m_hi = intf.A;
                3'd6: m_lo = intf.A;
                default: ;
            endcase
        end
    end

    logic exp_stall;
    always @(negedge clk) begin
        if (check_en) begin
            exp_stall = intf.md_use_D & ((m_left > 0) |
                ((intf.md_op >= 3'd1) && (intf.md_op <= 3'd4) && !intf.IntReq));
            chk("m_busy", {31'd0, intf.busy}, {31'd0, m_left > 0});
            chk("m_stall", {31'd0, intf.stall_md}, {31'd0, exp_stall});
            chk("m_hi", intf.HI, m_hi);
            chk("m_lo", intf.LO, m_lo);
            chk("m_out", intf.md_out, intf.rd_sel ? m_lo : m_hi);
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic intr);
        @(posedge clk); #1;
        intf.md_op = op; intf.A = a; intf.B = b; intf.IntReq = intr;
        @(posedge clk); #1;
        intf.md_op = 3'd0; intf.IntReq = 1'b0;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (intf.busy) cyc++;
            else break;
        end
    endtask

    int n;

    initial begin
        intf.md_op = 3'd0; intf.A = '0; intf.B = '0;
        intf.IntReq = 1'b0; intf.md_use_D = 1'b0; intf.rd_sel = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check_en = 1'b1;
        @(negedge clk);
        chk("rst_hi", intf.HI, 32'h0);
        chk("rst_lo", intf.LO, 32'h0);
        chk("rst_busy", {31'd0, intf.busy}, 32'd0);

        issue(3'd1, 32'hFFFFFFFF, 32'd2, 1'b0);
        wait_idle(n);
        chk("mult_cycles", n, 32'd5);
        chk("mult_hi", intf.HI, 32'hFFFFFFFF);
        chk("mult_lo", intf.LO, 32'hFFFFFFFE);

        issue(3'd2, 32'hFFFFFFFF, 32'd2, 1'b0);
        wait_idle(n);
        chk("multu_hi", intf.HI, 32'h00000001);
        chk("multu_lo", intf.LO, 32'hFFFFFFFE);

        @(posedge clk); #1;
        intf.md_op = 3'd2; intf.md_use_D = 1'b1;
        n = 0;
        @(negedge clk);
        if (intf.stall_md) n++;
        @(posedge clk); #1;
        intf.md_op = 3'd0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (intf.stall_md) n++;
            if (!intf.busy) break;
        end
        intf.md_use_D = 1'b0;
        chk("stall_cycles", n, 32'd6);

        issue(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
        wait_idle(n);
        chk("div_cycles", n, 32'd10);
        chk("div_lo", intf.LO, 32'hFFFFFFFD);
        chk("div_hi", intf.HI, 32'hFFFFFFFF);

        issue(3'd4, 32'hFFFFFFF9, 32'd2, 1'b0);
        wait_idle(n);
        chk("divu_lo", intf.LO, 32'h7FFFFFFC);
        chk("divu_hi", intf.HI, 32'h00000001);

        issue(3'd1, 32'd3, 32'd4, 1'b1);
        @(negedge clk);
        chk("int_busy", {31'd0, intf.busy}, 32'd0);
        chk("int_hi", intf.HI, 32'h00000001);
        issue(3'd6, 32'd5, 32'd0, 1'b1);
        @(negedge clk);
        chk("int_mtlo", intf.LO, 32'h7FFFFFFC);

        issue(3'd5, 32'h11, 32'd0, 1'b0);
        issue(3'd6, 32'h22, 32'd0, 1'b0);
        issue(3'd3, 32'h1234, 32'd0, 1'b0);
        wait_idle(n);
        chk("div0_cycles", n, 32'd10);
        chk("div0_hi", intf.HI, 32'h11);
        chk("div0_lo", intf.LO, 32'h22);

        issue(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        wait_idle(n);
        chk("divovf_lo", intf.LO, 32'h80000000);
        chk("divovf_hi", intf.HI, 32'h0);

        issue(3'd1, 32'd3, 32'd4, 1'b0);
        @(posedge clk); #1;
        intf.md_op = 3'd5; intf.A = 32'hDEAD;
        @(posedge clk); #1;
        intf.md_op = 3'd0;
        wait_idle(n);
        chk("ign_hi", intf.HI, 32'h0);
        chk("ign_lo", intf.LO, 32'd12);

        issue(3'd5, 32'hABCD, 32'd0, 1'b0);
        intf.rd_sel = 1'b0;
        @(negedge clk);
        chk("mthi_hi", intf.HI, 32'hABCD);
        chk("mf_hi", intf.md_out, 32'hABCD);
        intf.rd_sel = 1'b1;
        @(negedge clk);
        chk("mf_lo", intf.md_out, 32'd12);
        intf.rd_sel = 1'b0;

        issue(3'd1, 32'd7, 32'd9, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("pre_rst_busy", {31'd0, intf.busy}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", {31'd0, intf.busy}, 32'd0);
        chk("mid_rst_hi", intf.HI, 32'h0);
        chk("mid_rst_lo", intf.LO, 32'h0);

        repeat (12) @(negedge clk);
        chk("post_rst_lo", intf.LO, 32'h0);
        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
